usb_phy_rx: RTL and testbench
=============================

# usb_phy_rx

Receive-side USB full-speed PHY byte engine. Samples the synchronised D+/D- line state on each recovered bit strobe, performs NRZI decode, SYNC detection, bit-unstuffing and LSB-first byte assembly, and emits bytes on the `rx_lp_*` stream with SOP/EOP framing. It sits directly upstream of the link-layer receiver (token/CRC5 checker), which consumes `rx_lp_sop/eop/valid/data` and drives `rx_lp_ready`.

## Interface
- No parameters.
- `clk` input 1: single system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_bit_strobe` input 1: one-clk pulse per bit time from clock recovery; at most one pulse per 4 clk.
- `rx_dp` input 1: D+ line, already synchronised to `clk`.
- `rx_dm` input 1: D- line, already synchronised to `clk`.
- `rx_lp_valid` output 1: byte beat valid.
- `rx_lp_ready` input 1: downstream accepts beat when high with `rx_lp_valid`.
- `rx_lp_data` output 8: received byte.
- `rx_lp_sop` output 1: beat is first byte of packet.
- `rx_lp_eop` output 1: beat is last byte of packet (may coincide with SOP).
- `rx_active` output 1: high from SYNC detection until EOP J-state seen.
- `rx_err` output 1: one-clk pulse on stuff error, partial-byte EOP, or overflow.

## Operation
- Line states sampled only when `rx_bit_strobe`=1: J = dp1/dm0, K = dp0/dm1, SE0 = dp0/dm0; dp1/dm1 treated as J.
- NRZI decode: bit = 1 if state equals previous non-SE0 state, else 0. Previous state forced to J in IDLE.
- FSM states: IDLE, SYNC, DATA, EOP_WAIT.
- IDLE: on K -> SYNC; SE0 ignored.
- SYNC: shift decoded bits into 8-bit window; window (oldest first) 0,0,0,0,0,0,0,1 -> DATA, `rx_active`=1, ones-run=1, bit count=0, first-byte flag set. SE0 -> EOP_WAIT, no output.
- DATA: decoded 1 increments ones-run, 0 clears it. When ones-run is 6, next bit is a stuff bit: discarded, ones-run cleared. Other bits shift into byte LSB-first; count wraps 7->0 completing a byte.
- Completed byte goes to 8-bit hold register; if hold already full, previous hold byte is emitted first (SOP = first-byte flag, EOP=0; flag cleared on emission).
- SE0 in DATA -> EOP_WAIT. If hold full: emit it with EOP=1. If bit count != 0: additionally pulse `rx_err` (partial bits dropped). If hold empty: no beat.
- EOP_WAIT: on J -> IDLE, `rx_active`=0, all packet state cleared. K ignored.
- Output register: beat held stable until `rx_lp_valid & rx_lp_ready`. If an emission is required while a beat is still pending, new byte dropped and `rx_err` pulses; pending beat untouched.
- Reset at any point: FSM -> IDLE, hold and output registers cleared, partial packet discarded.

## Timing
- Reset values: `rx_lp_valid`=0, `rx_lp_data`=8'h00, `rx_lp_sop`=0, `rx_lp_eop`=0, `rx_active`=0, `rx_err`=0.
- Non-last byte: `rx_lp_valid` rises 1 clk after the strobe completing the following byte.
- Last byte: `rx_lp_valid` with EOP rises 1 clk after the strobe sampling the first SE0.
- `rx_active` rises 1 clk after the strobe completing SYNC; falls 1 clk after the strobe sampling J in EOP_WAIT.
- `rx_err` is exactly 1 clk wide; simultaneous error causes give one pulse.
- Valid-ready with strobe spacing >=4 clk: `rx_lp_ready` tied high never overflows.

## Configuration
- `USB_PHY_RX_STUFF_CHECK_EN` defined: stuff bit decoded as 1 (seventh consecutive 1) is an error: `rx_err` pulse, hold byte (if any) emitted with EOP=1, FSM -> EOP_WAIT.
- Not defined: stuff bit discarded regardless of value, no error, reception continues.

## Test plan
- SYNC then ACK PID 0xD2 then SE0,SE0,J -> one beat data=0xD2, sop=1, eop=1; `rx_active` high for packet; `rx_err` never.
- SYNC, IN token bytes 0x69, 0x81, 0x50, EOP -> three beats: 0x69 sop=1/eop=0, 0x81 sop=0/eop=0, 0x50 sop=0/eop=1.
- SYNC, PID 0xC3, data 0xFF with stuffed 0 after sixth 1, 0x01, EOP -> beats 0xC3, 0xFF, 0x01; no error.
- Macro defined: SYNC, 0x69, then seven consecutive 1s -> 0x69 emitted eop=1, `rx_err` 1 clk pulse, later bytes ignored until J; macro undefined -> no error.
- `rx_lp_ready`=0 during 3-byte token -> first beat 0x69 held stable, later bytes dropped, `rx_err` pulses; raise ready -> 0x69 accepted once.
- `rst_n` low mid-DATA after 0x69 and 4 bits -> all outputs reset values immediately; next clean SYNC+0xD2 packet received correctly.

Source files
------------

// File: rtl/usb_phy_rx.sv
// USB full-speed receive byte engine: NRZI decode, SYNC, unstuff, framing.
// Optional: USB_PHY_RX_STUFF_CHECK_EN flags a stuff bit decoded as 1.
module usb_phy_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_bit_strobe,
  input  logic       rx_dp,
  input  logic       rx_dm,
  output logic       rx_lp_valid,
  input  logic       rx_lp_ready,
  output logic [7:0] rx_lp_data,
  output logic       rx_lp_sop,
  output logic       rx_lp_eop,
  output logic       rx_active,
  output logic       rx_err
);

  typedef enum logic [1:0] {
    S_IDLE, S_SYNC, S_DATA, S_EOPW
  } state_t;

  state_t     r_state, w_state_nx;
  logic       r_prev;
  logic [7:0] r_win;
  logic [2:0] r_ones, r_cnt;
  logic [7:0] r_byte, r_hold;
  logic       r_hold_full, r_first;
  logic       r_valid, r_sop, r_eop;
  logic [7:0] r_data;
  logic       r_active, r_err;

  logic       w_se0, w_j, w_k, w_bit;
  logic [7:0] w_win_nx, w_new_byte;
  logic       w_emit, w_eop, w_err;
  logic       w_sync_hit, w_take, w_done, w_stuff;
  logic       w_pend, w_load, w_ovf;

  // dp1/dm1 is folded into J
  assign w_se0      = ~rx_dp & ~rx_dm;
  assign w_j        = rx_dp;
  assign w_k        = ~rx_dp & rx_dm;
  assign w_bit      = (w_j == r_prev);
  assign w_win_nx   = {r_win[6:0], w_bit};
  assign w_new_byte = {w_bit, r_byte[7:1]};

  assign w_pend = r_valid & ~rx_lp_ready;
  assign w_load = w_emit & ~w_pend;
  assign w_ovf  = w_emit & w_pend;

  always_comb begin
    w_state_nx = r_state;
    w_emit     = 1'b0;
    w_eop      = 1'b0;
    w_err      = 1'b0;
    w_sync_hit = 1'b0;
    w_take     = 1'b0;
    w_done     = 1'b0;
    w_stuff    = 1'b0;
    if (rx_bit_strobe) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_k) w_state_nx = S_SYNC;
        end
        S_SYNC: begin
          if (w_se0) begin
            w_state_nx = S_EOPW;
          end else if (w_win_nx == 8'h01) begin
            w_state_nx = S_DATA;
            w_sync_hit = 1'b1;
          end
        end
        S_DATA: begin
          if (w_se0) begin
            w_state_nx = S_EOPW;
            w_emit     = r_hold_full;
            w_eop      = 1'b1;
            w_err      = (r_cnt != 3'd0);
          end else if (r_ones == 3'd6) begin
            w_stuff = 1'b1;
`ifdef USB_PHY_RX_STUFF_CHECK_EN
            if (w_bit) begin
              w_state_nx = S_EOPW;
              w_emit     = r_hold_full;
              w_eop      = 1'b1;
              w_err      = 1'b1;
            end
`endif
          end else begin
            w_take = 1'b1;
            if (r_cnt == 3'd7) begin
              w_done = 1'b1;
              w_emit = r_hold_full;
            end
          end
        end
        S_EOPW: begin
          if (w_j) w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= 1'b1;
      r_win       <= 8'hFF;
      r_ones      <= 3'd0;
      r_cnt       <= 3'd0;
      r_byte      <= 8'h00;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_first     <= 1'b0;
      r_active    <= 1'b0;
      r_err       <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= 8'h00;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
    end else begin
      r_err <= w_err | w_ovf;
      if (rx_bit_strobe & ~w_se0) r_prev <= w_j;
      // window starts all-ones so only a full SYNC can match
      if (r_state == S_IDLE)
        r_win <= (rx_bit_strobe & w_k) ? 8'hFE : 8'hFF;
      else if (r_state == S_SYNC && rx_bit_strobe && !w_se0)
        r_win <= w_win_nx;
      if (w_sync_hit) begin
        r_ones      <= 3'd1;
        r_cnt       <= 3'd0;
        r_first     <= 1'b1;
        r_active    <= 1'b1;
        r_hold_full <= 1'b0;
      end
      if (w_stuff) r_ones <= 3'd0;
      if (w_take) begin
        r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
        r_byte <= w_new_byte;
        r_cnt  <= r_cnt + 3'd1;
      end
      if (w_done) begin
        r_hold      <= w_new_byte;
        r_hold_full <= 1'b1;
      end
      if (w_emit) r_first <= 1'b0;
      if (r_state == S_DATA && w_state_nx == S_EOPW)
        r_hold_full <= 1'b0;
      if (r_state == S_EOPW && w_state_nx == S_IDLE) begin
        r_active    <= 1'b0;
        r_hold_full <= 1'b0;
        r_first     <= 1'b0;
        r_cnt       <= 3'd0;
        r_ones      <= 3'd0;
        r_byte      <= 8'h00;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= r_hold;
        r_sop   <= r_first;
        r_eop   <= w_eop;
      end else if (r_valid & rx_lp_ready) begin
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
      end
    end
  end

  assign rx_lp_valid = r_valid;
  assign rx_lp_data  = r_data;
  assign rx_lp_sop   = r_sop;
  assign rx_lp_eop   = r_eop;
  assign rx_active   = r_active;
  assign rx_err      = r_err;

endmodule

// File: tb/tb_usb_phy_rx.sv
// Testbench for usb_phy_rx: NRZI line encoder driving the DUT,
// beat scoreboard and error-pulse counter.
module tb_usb_phy_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_bit_strobe;
  logic       rx_dp, rx_dm;
  logic       rx_lp_valid;
  logic       rx_lp_ready;
  logic [7:0] rx_lp_data;
  logic       rx_lp_sop, rx_lp_eop;
  logic       rx_active, rx_err;

  int checks = 0;
  int failures = 0;
  int errcnt = 0;
  logic [9:0] exp_q[$];
  logic lvl;
  int ones;

  usb_phy_rx dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_bit_strobe(rx_bit_strobe),
    .rx_dp(rx_dp),
    .rx_dm(rx_dm),
    .rx_lp_valid(rx_lp_valid),
    .rx_lp_ready(rx_lp_ready),
    .rx_lp_data(rx_lp_data),
    .rx_lp_sop(rx_lp_sop),
    .rx_lp_eop(rx_lp_eop),
    .rx_active(rx_active),
    .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  // scoreboard: each accepted beat pops one expected {data,sop,eop}
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n) begin
      if (rx_err) errcnt++;
      if (rx_lp_valid && rx_lp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected got=%h/%b/%b want=none",
                   rx_lp_data, rx_lp_sop, rx_lp_eop);
        end else begin
          e = exp_q.pop_front();
          if ({rx_lp_data, rx_lp_sop, rx_lp_eop} !== e) begin
            failures++;
            $display("FAIL beat got=%h/%b/%b want=%h/%b/%b",
                     rx_lp_data, rx_lp_sop, rx_lp_eop,
                     e[9:2], e[1], e[0]);
          end
        end
      end
    end
  end

  task automatic line(input logic dp, input logic dm);
    @(negedge clk);
    rx_dp = dp;
    rx_dm = dm;
    rx_bit_strobe = 1'b1;
    @(negedge clk);
    rx_bit_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic raw_bit(input logic b);
    if (!b) lvl = ~lvl;
    line(lvl, ~lvl);
  endtask

  task automatic send_bit(input logic b);
    raw_bit(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      raw_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_sync();
    lvl = 1'b1;
    for (int i = 0; i < 7; i++) raw_bit(1'b0);
    raw_bit(1'b1);
    ones = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_eop();
    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    lvl = 1'b1;
    line(1'b1, 1'b0);
    line(1'b1, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_bit_strobe = 1'b0;
    rx_dp = 1'b1;
    rx_dm = 1'b0;
    rx_lp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {7'd0, rx_lp_valid}, 8'd0);
    chk("rst_data", rx_lp_data, 8'h00);
    chk("rst_sop", {7'd0, rx_lp_sop}, 8'd0);
    chk("rst_eop", {7'd0, rx_lp_eop}, 8'd0);
    chk("rst_active", {7'd0, rx_active}, 8'd0);
    chk("rst_err", {7'd0, rx_err}, 8'd0);
    rst_n = 1'b1;
    lvl = 1'b1;
    line(1'b1, 1'b0);
  endtask

  task automatic test_ack();
    errcnt = 0;
    exp_q.push_back({8'hD2, 1'b1, 1'b1});
    send_sync();
    chk("ack_active_hi", {7'd0, rx_active}, 8'd1);
    send_byte(8'hD2);
    line(1'b0, 1'b0);
    chk("ack_beat_done", exp_q.size(), 0);
    chk("ack_active_eop", {7'd0, rx_active}, 8'd1);
    line(1'b0, 1'b0);
    lvl = 1'b1;
    line(1'b1, 1'b0);
    chk("ack_active_lo", {7'd0, rx_active}, 8'd0);
    chk("ack_err", errcnt, 0);
  endtask

  task automatic test_token();
    errcnt = 0;
    exp_q.push_back({8'h69, 1'b1, 1'b0});
    exp_q.push_back({8'h81, 1'b0, 1'b0});
    exp_q.push_back({8'h50, 1'b0, 1'b1});
    send_sync();
    send_byte(8'h69);
    send_byte(8'h81);
    send_byte(8'h50);
    send_eop();
    chk("tok_beats", exp_q.size(), 0);
    chk("tok_err", errcnt, 0);
  endtask

  task automatic test_stuff();
    errcnt = 0;
    exp_q.push_back({8'hC3, 1'b1, 1'b0});
    exp_q.push_back({8'hFF, 1'b0, 1'b0});
    exp_q.push_back({8'h01, 1'b0, 1'b1});
    send_sync();
    send_byte(8'hC3);
    send_byte(8'hFF);
    send_byte(8'h01);
    send_eop();
    chk("stuff_beats", exp_q.size(), 0);
    chk("stuff_err", errcnt, 0);
  endtask

  task automatic test_stuff_err();
    errcnt = 0;
`ifdef USB_PHY_RX_STUFF_CHECK_EN
    exp_q.push_back({8'h69, 1'b1, 1'b1});
`else
    exp_q.push_back({8'h69, 1'b1, 1'b0});
    exp_q.push_back({8'hFF, 1'b0, 1'b1});
`endif
    send_sync();
    send_byte(8'h69);
    for (int i = 0; i < 9; i++) raw_bit(1'b1);
    chk("serr_active", {7'd0, rx_active}, 8'd1);
    send_eop();
    chk("serr_beats", exp_q.size(), 0);
`ifdef USB_PHY_RX_STUFF_CHECK_EN
    chk("serr_err", errcnt, 1);
`else
    chk("serr_err", errcnt, 0);
`endif
  endtask

  task automatic test_backpressure();
    errcnt = 0;
    rx_lp_ready = 1'b0;
    send_sync();
    send_byte(8'h69);
    send_byte(8'h81);
    chk("bp_valid1", {7'd0, rx_lp_valid}, 8'd1);
    chk("bp_data1", rx_lp_data, 8'h69);
    send_byte(8'h50);
    send_eop();
    chk("bp_valid", {7'd0, rx_lp_valid}, 8'd1);
    chk("bp_data", rx_lp_data, 8'h69);
    chk("bp_sop", {7'd0, rx_lp_sop}, 8'd1);
    chk("bp_eop", {7'd0, rx_lp_eop}, 8'd0);
    chk("bp_err", errcnt, 2);
    exp_q.push_back({8'h69, 1'b1, 1'b0});
    rx_lp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_drain", exp_q.size(), 0);
    chk("bp_valid_lo", {7'd0, rx_lp_valid}, 8'd0);
  endtask

  task automatic test_reset_mid();
    send_sync();
    send_byte(8'h69);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("mid_active_pre", {7'd0, rx_active}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", {7'd0, rx_lp_valid}, 8'd0);
    chk("mid_data", rx_lp_data, 8'h00);
    chk("mid_sop", {7'd0, rx_lp_sop}, 8'd0);
    chk("mid_eop", {7'd0, rx_lp_eop}, 8'd0);
    chk("mid_active", {7'd0, rx_active}, 8'd0);
    chk("mid_err", {7'd0, rx_err}, 8'd0);
    lvl = 1'b1;
    rx_dp = 1'b1;
    rx_dm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    line(1'b1, 1'b0);
    errcnt = 0;
    exp_q.push_back({8'hD2, 1'b1, 1'b1});
    send_sync();
    send_byte(8'hD2);
    send_eop();
    chk("mid_pkt", exp_q.size(), 0);
    chk("mid_pkt_err", errcnt, 0);
  endtask

  initial begin
    test_reset();
    test_ack();
    test_token();
    test_stuff();
    test_stuff_err();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
